// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encodings,
// the full-word byte-enable constant and a width helper for the watchdog.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_D = 2'b01,
    ARB_GNT_I = 2'b10
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic int wdog_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/arb_wdog.sv
// Bus watchdog: counts granted cycles without an acknowledge and flags the
// cycle in which the TIMEOUT_CYC-th such cycle is reached (0 disables it).
module arb_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  import mem_port_arbiter_pkg::*;

  localparam int CW = wdog_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic WDOG_ON = (TIMEOUT_CYC != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear on a new grant, advance while waiting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && WDOG_ON) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // en_i already excludes ack cycles, so an ack on the terminal count wins
  assign tc_o = WDOG_ON && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the IF fetch port and the MEM load/store port,
// with data priority, alternating service, fetch kill on redirect and a watchdog.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout
);
  import mem_port_arbiter_pkg::*;

  arb_state_e    state_q, state_d;
  logic          kill_q, kill_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;

  logic busy_s, tc_s, fin_s;
  logic grant_d_s, grant_i_s, release_s;

  assign busy_s = (state_q != ARB_IDLE);
  assign fin_s  = busy_s & (bus_ack | tc_s);

  // arbitration, kill tracking and bus field capture on the grant edge
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    grant_d_s   = 1'b0;
    grant_i_s   = 1'b0;
    release_s   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (d_req) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = if_req & ~if_flush;
        end
      end
      ARB_GNT_D: begin
        grant_i_s = fin_s & if_req & ~if_flush;
        release_s = fin_s;
      end
      ARB_GNT_I: begin
        grant_d_s = fin_s & d_req;
        release_s = fin_s;
        if (fin_s) begin
          kill_d = 1'b0;
        end else if (if_flush) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      default: begin
        release_s = 1'b1;
        kill_d    = 1'b0;
      end
    endcase

    if (grant_d_s) begin
      state_d     = ARB_GNT_D;
      bus_req_d   = 1'b1;
      bus_we_d    = d_we;
      bus_addr_d  = d_addr;
      bus_wdata_d = d_wdata;
      bus_be_d    = d_be;
    end else if (grant_i_s) begin
      state_d     = ARB_GNT_I;
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b0;
      bus_addr_d  = if_addr;
      bus_wdata_d = '0;
      bus_be_d    = BE_WORD;
    end else if (release_s) begin
      state_d   = ARB_IDLE;
      bus_req_d = 1'b0;
    end else begin
      state_d   = state_q;
      bus_req_d = bus_req_q;
    end
  end

  // state and bus registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      kill_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk  (clk),
    .reset(reset),
    .clr_i(grant_d_s | grant_i_s),
    .en_i (busy_s & ~bus_ack),
    .tc_o (tc_s)
  );

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

  // a killed fetch finishes on the bus but is never reported to IF
  assign d_done   = (state_q == ARB_GNT_D) & fin_s;
  assign if_done  = (state_q == ARB_GNT_I) & fin_s & ~kill_q & ~if_flush;
  assign timeout  = tc_s & (d_done | if_done);
  assign d_rdata  = ((state_q == ARB_GNT_D) && bus_ack && !bus_we_q) ? bus_rdata : '0;
  assign if_rdata = ((state_q == ARB_GNT_I) && bus_ack) ? bus_rdata : '0;

  assign stall_if  = (if_req & ~if_done) | ((state_q == ARB_GNT_I) & kill_q);
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: pipeline-side drivers push per-port expectations, a bus
// responder model plays memory, and a monitor checks every completion.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = 4'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic        if_done, d_done, bus_req, bus_we, stall_if, stall_mem, timeout;
  logic [3:0]  bus_be;

  typedef struct { logic [31:0] rdata; logic to; } exp_t;
  typedef struct { byte port; int st; int en; } txn_t;

  exp_t d_exp_q[$], i_exp_q[$];
  int   d_lat_q[$], i_lat_q[$];
  txn_t log_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int   total = 0, bad = 0;
  bit   stray = 1'b0;

  bit   r_in_txn = 1'b0;
  int   r_c = 0, r_lat = 0, r_st = 0, r_cyc = 0;
  byte  r_port = "D";
  exp_t mon_e;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  // Memory model on the bus: acks in cycle 'lat' of each transaction, 0 = never.
  initial begin : responder
    forever begin
      @(posedge clk); #2;
      r_cyc++;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (reset) begin
        r_in_txn = 1'b0;
      end else begin
        if (!r_in_txn && bus_req) begin
          r_in_txn = 1'b1; r_c = 0; r_st = r_cyc; r_lat = 1;
          r_port = (bus_addr < 32'h0000_1000) ? "I" : "D";
          if (r_port == "I") begin
            chk("bus_we_fetch", bus_we, 1'b0);
            chk("bus_be_fetch", bus_be, 4'hF);
            chk("bus_addr_fetch", bus_addr, if_addr);
            if (i_lat_q.size() == 0) chk("fetch_unexpected_txn", 1, 0);
            else r_lat = i_lat_q.pop_front();
          end else begin
            chk("bus_we_data", bus_we, d_we);
            chk("bus_be_data", bus_be, d_be);
            chk("bus_addr_data", bus_addr, d_addr);
            if (d_we) chk("bus_wdata", bus_wdata, d_wdata);
            if (d_lat_q.size() == 0) chk("data_unexpected_txn", 1, 0);
            else r_lat = d_lat_q.pop_front();
          end
        end
        if (r_in_txn) begin
          r_c++;
          if (r_c == r_lat) begin
            bus_ack = 1'b1;
            if (r_port == "I") bus_rdata = imem_word(bus_addr);
            else if (!bus_we) bus_rdata = rd_mem(bus_addr);
            r_in_txn = 1'b0;
            log_q.push_back('{port: r_port, st: r_st, en: r_cyc});
          end else if (r_c == TO) begin
            r_in_txn = 1'b0;
            log_q.push_back('{port: r_port, st: r_st, en: r_cyc});
          end
        end else if (stray) begin
          bus_ack = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: every done pops that port's oldest expectation.
  always @(negedge clk) begin
    if (d_done) begin
      if (d_exp_q.size() == 0) chk("d_done_unexpected", 1, 0);
      else begin
        mon_e = d_exp_q.pop_front();
        chk("d_rdata", d_rdata, mon_e.rdata);
        chk("d_timeout", timeout, mon_e.to);
      end
    end
    if (if_done) begin
      if (i_exp_q.size() == 0) chk("if_done_unexpected", 1, 0);
      else begin
        mon_e = i_exp_q.pop_front();
        chk("if_rdata", if_rdata, mon_e.rdata);
        chk("if_timeout", timeout, mon_e.to);
      end
    end
    if (timeout && !d_done && !if_done) chk("timeout_without_done", 1, 0);
  end

  task automatic wait_done(input bit is_d);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (is_d) begin
        if (d_done) begin got = 1'b1; chk("stall_mem_on_done", stall_mem, 1'b0); end
        else chk("stall_mem_waiting", stall_mem, 1'b1);
      end else begin
        if (if_done) begin got = 1'b1; chk("stall_if_on_done", stall_if, 1'b0); end
        else chk("stall_if_waiting", stall_if, 1'b1);
      end
    end
    if (!got) chk(is_d ? "d_done_wait" : "if_done_wait", 0, 1);
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int lat);
    exp_t e;
    e = '{rdata: (lat == 0) ? 32'h0 : imem_word(a), to: (lat == 0)};
    if_req = 1'b1; if_addr = a;
    i_lat_q.push_back(lat); i_exp_q.push_back(e);
    wait_done(1'b0);
  endtask

  task automatic data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int lat);
    exp_t e;
    logic [31:0] m;
    if (lat == 0) e = '{rdata: 32'h0, to: 1'b1};
    else if (we) begin
      e = '{rdata: 32'h0, to: 1'b0};
      m = rd_mem(a);
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a] = m;
    end else e = '{rdata: rd_mem(a), to: 1'b0};
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    d_lat_q.push_back(lat); d_exp_q.push_back(e);
    wait_done(1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish within limit");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);   chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0); chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_be, 0);     chk("rst_dones", {if_done, d_done, timeout}, 0);
    @(posedge clk); #1; reset = 1'b0;

    // acks while idle must be ignored
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_bus_req", bus_req, 0);
      chk("stray_done", {if_done, d_done}, 0);
    end
    stray = 1'b0;
    @(posedge clk); #1;

    // lone fetch
    log_q.delete();
    fetch(32'h0000_0100, 2);
    chk("t1_txn_count", log_q.size(), 1);

    // simultaneous requests: data first, fetch back-to-back
    log_q.delete();
    fork
      data(1'b0, 32'h0000_2000, 32'h0, 4'hF, 2);
      fetch(32'h0000_0104, 2);
    join
    chk("t2_txn_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_first_D", log_q[0].port, "D");
      chk("t2_second_I", log_q[1].port, "I");
      chk("t2_no_gap", log_q[1].st, log_q[0].en + 1);
    end

    // continuous load on both ports alternates service
    log_q.delete();
    fork
      begin
        for (int k = 0; k < 3; k++)
          data((k % 2) == 1, 32'h0000_2000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'hF, 1);
      end
      begin
        for (int j = 0; j < 3; j++) fetch(32'h0000_0110 + 32'(4 * j), 1);
      end
    join
    chk("t3_txn_count", log_q.size(), 6);
    for (int j = 0; j < log_q.size(); j++) begin
      chk("t3_alternate", log_q[j].port, (j % 2 == 0) ? "D" : "I");
      if (j > 0) chk("t3_no_gap", log_q[j].st, log_q[j-1].en + 1);
    end

    // redirect during a fetch: old result discarded, new address fetched
    log_q.delete();
    if_req = 1'b1; if_addr = 32'h0000_0108;
    i_lat_q.push_back(3); i_lat_q.push_back(2);
    i_exp_q.push_back('{rdata: imem_word(32'h0000_0200), to: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1; if_flush = 1'b1; if_addr = 32'h0000_0200;
    @(posedge clk); #1; if_flush = 1'b0;
    @(negedge clk);
    chk("t4_stall_while_killed", stall_if, 1);
    chk("t4_no_done_killed", if_done, 0);
    wait_done(1'b0);
    chk("t4_txn_count", log_q.size(), 2);

    // watchdog abort, then ack on the terminal cycle
    log_q.delete();
    data(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 0);
    chk("t5_bus_req_dropped", bus_req, 0);
    if (log_q.size() == 1) chk("t5_req_cycles", log_q[0].en - log_q[0].st + 1, TO);
    else chk("t5_txn_count", log_q.size(), 1);
    data(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h3, TO);
    data(1'b0, 32'h0000_3000, 32'h0, 4'hF, 1);

    // reset in the middle of a data grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2004; d_be = 4'hF;
    d_lat_q.push_back(0); d_lat_q.push_back(3);
    d_exp_q.push_back('{rdata: rd_mem(32'h0000_2004), to: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("t6_bus_req_async", bus_req, 0);
    chk("t6_bus_addr_async", bus_addr, 0);
    @(negedge clk); chk("t6_no_done_in_reset", d_done, 0);
    @(posedge clk); #1; reset = 1'b0;
    wait_done(1'b1);

    // randomized traffic on both ports
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          int g, r;
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clk); #1; end
          r = $urandom_range(0, 9);
          data(1'($urandom_range(0, 1)), 32'h0001_0000 + 32'(4 * $urandom_range(0, 15)),
               $urandom, 4'($urandom_range(1, 15)), (r < 2) ? 0 : $urandom_range(1, TO));
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          int g, r;
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clk); #1; end
          r = $urandom_range(0, 9);
          fetch(32'(4 * $urandom_range(0, 1023)), (r < 2) ? 0 : $urandom_range(1, TO));
        end
      end
    join

    repeat (3) @(posedge clk);
    chk("end_d_exp_empty", d_exp_q.size(), 0);
    chk("end_i_exp_empty", i_exp_q.size(), 0);
    chk("end_d_lat_empty", d_lat_q.size(), 0);
    chk("end_i_lat_empty", i_lat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
